// File: rtl/seven_segment_bcd.sv
// Binary (0..31) to two-digit 7-segment display driver with registered outputs.
// Optional build macro SEVEN_SEGMENT_BCD_LEADING_ZERO_BLANK_EN blanks a leading zero tens digit.
module seven_segment_bcd #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] number,
   output logic [6:0] tens_digit,
   output logic [6:0] ones_digit
);

   localparam logic [6:0] SEG_BLANK = 7'b000_0000;
   localparam logic [6:0] POL_MASK  = {7{ACTIVE_LOW}};

   logic [1:0] tens_val;
   logic [3:0] ones_val;
   logic [6:0] tens_seg;
   logic [6:0] ones_seg;

   // Segment order g f e d c b a, lit = 1.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b011_1111;
         4'd1:    seg = 7'b000_0110;
         4'd2:    seg = 7'b101_1011;
         4'd3:    seg = 7'b100_1111;
         4'd4:    seg = 7'b110_0110;
         4'd5:    seg = 7'b110_1101;
         4'd6:    seg = 7'b111_1101;
         4'd7:    seg = 7'b000_0111;
         4'd8:    seg = 7'b111_1111;
         4'd9:    seg = 7'b110_1111;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Range compare instead of a divider: only four possible tens values.
   always_comb begin
      tens_val = 2'd0;
      ones_val = number[3:0];
      if (number >= 5'd30) begin
         tens_val = 2'd3;
         ones_val = 4'(number - 5'd30);
      end else if (number >= 5'd20) begin
         tens_val = 2'd2;
         ones_val = 4'(number - 5'd20);
      end else if (number >= 5'd10) begin
         tens_val = 2'd1;
         ones_val = 4'(number - 5'd10);
      end
   end

   always_comb begin
`ifdef SEVEN_SEGMENT_BCD_LEADING_ZERO_BLANK_EN
      tens_seg = (tens_val == 2'd0) ? SEG_BLANK : seg_decode({2'b00, tens_val});
`else
      tens_seg = seg_decode({2'b00, tens_val});
`endif
      ones_seg = seg_decode(ones_val);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tens_digit <= SEG_BLANK ^ POL_MASK;
         ones_digit <= SEG_BLANK ^ POL_MASK;
      end else begin
         tens_digit <= tens_seg ^ POL_MASK;
         ones_digit <= ones_seg ^ POL_MASK;
      end
   end

endmodule

// File: tb/tb_seven_segment_bcd.sv
// Scoreboard bench for seven_segment_bcd: active-high and active-low instances share stimulus.
module tb_seven_segment_bcd;

   logic       clk;
   logic       reset;
   logic [4:0] number;
   logic [6:0] tens_hi, ones_hi;
   logic [6:0] tens_lo, ones_lo;

   typedef struct packed {
      logic [6:0] tens;
      logic [6:0] ones;
   } exp_t;

   exp_t sb_q[$];
   int   total_cnt;
   int   fail_cnt;

   seven_segment_bcd #(.ACTIVE_LOW(1'b0)) dut_hi (
      .clk(clk), .reset(reset), .number(number),
      .tens_digit(tens_hi), .ones_digit(ones_hi)
   );

   seven_segment_bcd #(.ACTIVE_LOW(1'b1)) dut_lo (
      .clk(clk), .reset(reset), .number(number),
      .tens_digit(tens_lo), .ones_digit(ones_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] model_seg(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic exp_t model(input logic rst, input int num);
      exp_t e;
      if (rst) begin
         e.tens = 7'b0000000;
         e.ones = 7'b0000000;
      end else begin
         e.tens = model_seg(num / 10);
         e.ones = model_seg(num % 10);
`ifdef SEVEN_SEGMENT_BCD_LEADING_ZERO_BLANK_EN
         if (num / 10 == 0) e.tens = 7'b0000000;
`endif
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v, input int num);
      total_cnt++;
      assert (obs === exp_v) else begin
         fail_cnt++;
         $error("FAIL %s (number=%0d): observed %b expected %b", tag, num, obs, exp_v);
      end
   endtask

   // Drive one input pair, push its expectation, clock once, pop and compare.
   task automatic step(input logic rst, input int num);
      exp_t e;
      reset  = rst;
      number = 5'(num);
      sb_q.push_back(model(rst, num));
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         total_cnt++;
         fail_cnt++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         check("tens_hi", tens_hi, e.tens, num);
         check("ones_hi", ones_hi, e.ones, num);
         check("tens_lo", tens_lo, ~e.tens, num);
         check("ones_lo", ones_lo, ~e.ones, num);
      end
   endtask

   initial begin
      total_cnt = 0;
      fail_cnt  = 0;
      reset     = 1'b1;
      number    = 5'd0;

      step(1'b1, 17);
      step(1'b1, 17);
      step(1'b0, 17);

      step(1'b0, 0);

      for (int i = 0; i < 32; i++) step(1'b0, i);

      step(1'b0, 31);
      step(1'b0, 0);

      step(1'b0, 25);
      step(1'b1, 25);
      step(1'b0, 25);

      for (int i = 18; i < 27; i++) step(1'b0 || (i == 22), i);

      for (int i = 0; i < 12; i++) step(1'b0, int'($urandom_range(0, 31)));

      step(1'b1, 9);
      step(1'b0, 9);
      step(1'b0, 10);

      $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/seven_segment_bcd.md
Name: seven_segment_bcd

Overview:
- Converts a 5-bit unsigned binary value (0..31) into two decimal digits, tens and ones, and drives each as a 7-segment pattern.
- Outputs are registered on the single system clock.
- Sits between any counter/score/status register and a two-digit 7-segment display.

Parameters:
- ACTIVE_LOW, 0, segment polarity. 0 means a lit segment is driven 1. 1 means every output bit is inverted, for common-anode displays.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- number  input  5  unsigned binary value to display, 0..31.
- tens_digit  output  7  segment pattern for the tens digit, bit order [6:0] = g f e d c b a.
- ones_digit  output  7  segment pattern for the ones digit, same bit order.

Behaviour:
- Decimal split:
  - tens = number / 10, giving 0..3.
  - ones = number % 10, giving 0..9.
  - Every 5-bit input is legal and no overflow is possible.
- Segment encoding, active-high, g..a:
  - 0 = 0111111
  - 1 = 0000110
  - 2 = 1011011
  - 3 = 1001111
  - 4 = 1100110
  - 5 = 1101101
  - 6 = 1111101
  - 7 = 0000111
  - 8 = 1111111
  - 9 = 1101111
- The decoder includes a default branch, unreachable for legal digits, that drives the blank pattern 0000000.
- With ACTIVE_LOW=1, both outputs are the bitwise inverse of the table, including the reset and blank values.
- Latency is exactly one clock.
  - number sampled at rising edge N appears on both outputs after edge N.
  - Both digits always update in the same cycle; no mixed old/new pair is ever visible.
- Throughput: a new value every cycle. No handshake; the outputs continuously follow the input one cycle later.
- Reset:
  - While reset is high at a rising edge, both outputs go to blank: 0000000, or 1111111 when ACTIVE_LOW=1.
  - Reset takes priority over number.
  - Reset asserted mid-stream blanks the outputs on the next edge.
  - On release, the first edge with reset low loads the decoded value of number.
- Boundaries:
  - number=0 displays "00".
  - 9→10 changes both digits in one cycle (tens 0→1, ones 9→0).
  - 31 displays "31".
  - A wrap from 31 to 0 displays "00" one cycle later.
- No internal state beyond the two 7-bit output registers. The decode logic is purely combinational ahead of them.

Optional Feature:
- Macro: SEVEN_SEGMENT_BCD_LEADING_ZERO_BLANK_EN
- When defined: if tens = 0 (number 0..9), tens_digit is registered as blank (0000000, inverted under ACTIVE_LOW) instead of the "0" pattern. ones_digit is unaffected, so number=0 shows a blank tens and "0" ones.
- When not defined: the tens digit always shows its numeral, including a leading "0".
- Latency and reset behaviour are identical in both builds.

Test Plan:
- Reset held 2 cycles with number=17 -> both outputs 0000000; first edge after release -> tens 0000110, ones 0000111.
- number=0 applied, then one edge -> tens 0111111, ones 0111111. With the blank macro defined -> tens 0000000, ones 0111111.
- Sweep number 0..31, one value per cycle -> each output pair matches the value applied one cycle earlier.
  - Check 9→10: tens 0111111→0000110, ones 1101111→0111111, both in the same cycle.
  - Check 30: tens 1001111, ones 0111111.
- number=31 -> tens 1001111, ones 0000110; then number=0 -> "00" pattern one cycle later.
- ACTIVE_LOW=1 instance, number=25 -> tens 0100100 (inverse of 1011011), ones 0010010; reset -> both 1111111.
- Reset asserted mid-sweep at number=22 -> blank on the next edge; after release, the current number is decoded with 1-cycle latency.
